// File: rtl/time_set_ctrl.sv
// Time/alarm setting sequencer: mode stepping, increment strobes with auto-repeat, blink mask.
// Optional `SET_TIMEOUT_EN: idle set states fall back to NORMAL after TIMEOUT_S seconds.
module time_set_ctrl #(
    parameter int REPEAT_DLY = 10,
    parameter int TIMEOUT_S  = 30
) (
    input  logic       clk,
    input  logic       CR,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       tick_10hz,
    input  logic       tick_1hz,
    output logic [2:0] mode,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       inc_ahr,
    output logic       inc_amin,
    output logic       sec_hold,
    output logic       alm_view,
    output logic [3:0] blink
);

    localparam logic [2:0] NORMAL   = 3'b000;
    localparam logic [2:0] SET_HR   = 3'b001;
    localparam logic [2:0] SET_MIN  = 3'b010;
    localparam logic [2:0] SET_AHR  = 3'b011;
    localparam logic [2:0] SET_AMIN = 3'b100;

    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_DLY);

    logic [2:0]    state_q, state_d;
    logic          km_q, ku_q, arm_q;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          phase_q, phase_d;
    logic [3:0]    inc_q, inc_d;

    logic mode_edge, up_edge, in_set, chg;
    logic rpt_fire, strobe, timeout;

    // arm_q masks the first cycle after reset so a key already held is not an edge
    assign mode_edge = arm_q & key_mode & ~km_q;
    assign up_edge   = arm_q & key_up & ~ku_q;

    assign in_set = (state_q == SET_HR) | (state_q == SET_MIN)
                  | (state_q == SET_AHR) | (state_q == SET_AMIN);

`ifdef SET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_S);

    logic [TW-1:0] to_q, to_d;

    assign timeout = in_set & (to_q == TO_MAX) & ~mode_edge & ~up_edge;

    always_comb begin
        to_d = to_q;
        if (!in_set || mode_edge || up_edge || chg) begin
            to_d = '0;
        end else if (tick_1hz && to_q != TO_MAX) begin
            to_d = to_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:   if (mode_edge) state_d = SET_HR;
            SET_HR:   if (mode_edge) state_d = SET_MIN;
            SET_MIN:  if (mode_edge) state_d = SET_AHR;
            SET_AHR:  if (mode_edge) state_d = SET_AMIN;
            SET_AMIN: if (mode_edge) state_d = NORMAL;
            default:  state_d = NORMAL;
        endcase
        if (timeout) begin
            state_d = NORMAL;
        end
    end

    assign chg = (state_d != state_q);

    assign rpt_fire = in_set & key_up & tick_10hz & (rpt_q == RPT_MAX);
    assign strobe   = in_set & ~mode_edge & ~chg & (up_edge | rpt_fire);

    always_comb begin
        inc_d = 4'b0000;
        if (strobe) begin
            case (state_q)
                SET_HR:   inc_d = 4'b0001;
                SET_MIN:  inc_d = 4'b0010;
                SET_AHR:  inc_d = 4'b0100;
                SET_AMIN: inc_d = 4'b1000;
                default:  inc_d = 4'b0000;
            endcase
        end
    end

    always_comb begin
        rpt_d = rpt_q;
        if (!key_up || chg) begin
            rpt_d = '0;
        end else if (in_set && tick_10hz && rpt_q != RPT_MAX) begin
            rpt_d = rpt_q + RW'(1);
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (chg) begin
            phase_d = 1'b0;
        end else if (tick_1hz) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            km_q    <= 1'b0;
            ku_q    <= 1'b0;
            arm_q   <= 1'b0;
            rpt_q   <= '0;
            phase_q <= 1'b0;
            inc_q   <= 4'b0000;
        end else begin
            km_q    <= key_mode;
            ku_q    <= key_up;
            arm_q   <= 1'b1;
            rpt_q   <= rpt_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
        end
    end

    // ku_q stands in for key_up so blink has no input-to-output path
    always_comb begin
        sec_hold = 1'b0;
        alm_view = 1'b0;
        blink    = 4'b0000;
        case (state_q)
            SET_HR: begin
                sec_hold   = 1'b1;
                blink[3:2] = {2{phase_q}};
            end
            SET_MIN: begin
                sec_hold   = 1'b1;
                blink[1:0] = {2{phase_q}};
            end
            SET_AHR: begin
                alm_view   = 1'b1;
                blink[3:2] = {2{phase_q}};
            end
            SET_AMIN: begin
                alm_view   = 1'b1;
                blink[1:0] = {2{phase_q}};
            end
            default: ;
        endcase
        if (ku_q) begin
            blink = 4'b0000;
        end
    end

    assign mode     = state_q;
    assign inc_hr   = inc_q[0];
    assign inc_min  = inc_q[1];
    assign inc_ahr  = inc_q[2];
    assign inc_amin = inc_q[3];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed scenarios plus random stimulus,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_time_set_ctrl;

    localparam int REPEAT_DLY = 10;
    localparam int TIMEOUT_S  = 30;

    logic       clk = 1'b0;
    logic       CR = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_up = 1'b0;
    logic       tick_10hz = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [2:0] mode;
    logic       inc_hr, inc_min, inc_ahr, inc_amin;
    logic       sec_hold, alm_view;
    logic [3:0] blink;

    time_set_ctrl #(
        .REPEAT_DLY(REPEAT_DLY),
        .TIMEOUT_S (TIMEOUT_S)
    ) dut (
        .clk      (clk),
        .CR       (CR),
        .key_mode (key_mode),
        .key_up   (key_up),
        .tick_10hz(tick_10hz),
        .tick_1hz (tick_1hz),
        .mode     (mode),
        .inc_hr   (inc_hr),
        .inc_min  (inc_min),
        .inc_ahr  (inc_ahr),
        .inc_amin (inc_amin),
        .sec_hold (sec_hold),
        .alm_view (alm_view),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cnt[4] = '{0, 0, 0, 0};
    int base[4];

    logic [12:0] exp_q[$];

    // Model state: position in the 5-state ring, key history, held-tick count
    int m_st, m_held, m_to;
    bit m_arm, m_pkm, m_pku, m_ph;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic model_step();
        bit me, ue, ins, chg, fire, sec, alm;
        int nst;
        logic [3:0] inc, bl;
        if (CR) begin
            m_st = 0; m_held = 0; m_to = 0;
            m_arm = 0; m_pkm = 0; m_pku = 0; m_ph = 0;
            exp_q.delete();
            return;
        end
        me  = m_arm && key_mode && !m_pkm;
        ue  = m_arm && key_up && !m_pku;
        ins = (m_st != 0);
        nst = m_st;
        if (me) nst = (m_st + 1) % 5;
`ifdef SET_TIMEOUT_EN
        else if (ins && !ue && m_to >= TIMEOUT_S) nst = 0;
`endif
        chg  = (nst != m_st);
        fire = ins && !me && !chg
            && (ue || (tick_10hz && key_up && m_held >= REPEAT_DLY));
        inc = fire ? 4'(1 << (m_st - 1)) : 4'b0000;
        if (!key_up || chg) m_held = 0;
        else if (ins && tick_10hz) m_held++;
        if (!ins || me || ue || chg) m_to = 0;
        else if (tick_1hz) m_to++;
        if (chg) m_ph = 0;
        else if (tick_1hz) m_ph = !m_ph;
        m_arm = 1; m_pkm = key_mode; m_pku = key_up; m_st = nst;
        bl = 4'b0000;
        if (!key_up) begin
            if (nst == 1 || nst == 3) bl = {m_ph, m_ph, 2'b00};
            if (nst == 2 || nst == 4) bl = {2'b00, m_ph, m_ph};
        end
        sec = (nst == 1 || nst == 2);
        alm = (nst == 3 || nst == 4);
        exp_q.push_back({3'(nst), inc, sec, alm, bl});
    endtask

    initial forever begin
        @(posedge clk or posedge CR);
        model_step();
    end

    initial forever begin
        logic [12:0] got, want;
        @(posedge clk);
        #1;
        if (!CR) begin
            got = {mode, inc_amin, inc_ahr, inc_min, inc_hr,
                   sec_hold, alm_view, blink};
            if (inc_hr)   cnt[0]++;
            if (inc_min)  cnt[1]++;
            if (inc_ahr)  cnt[2]++;
            if (inc_amin) cnt[3]++;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                want = exp_q.pop_front();
                check("scoreboard", int'(got), int'(want));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) base[i] = cnt[i];
    endtask

    task automatic tick10();
        tick_10hz = 1'b1;
        cyc(1);
        tick_10hz = 1'b0;
        cyc(2);
    endtask

    task automatic tick1();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        cyc(2);
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        cyc(2);
        key_mode = 1'b0;
        cyc(2);
    endtask

    initial begin
        int mseq[5] = '{1, 2, 3, 4, 0};

        // reset with both keys already held
        key_mode = 1'b1;
        key_up   = 1'b1;
        cyc(3);
        check("rst_mode", int'(mode), 0);
        check("rst_blink", int'(blink), 0);
        check("rst_inc", int'({inc_hr, inc_min, inc_ahr, inc_amin}), 0);
        check("rst_hold", int'({sec_hold, alm_view}), 0);
        CR = 1'b0;
        cyc(10);
        check("held_keys_no_edge_mode", int'(mode), 0);
        check("held_keys_no_strobe", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
        key_mode = 1'b0;
        key_up   = 1'b0;
        cyc(3);

        // mode ring, each change visible one cycle after the edge
        for (int i = 0; i < 5; i++) begin
            key_mode = 1'b1;
            @(posedge clk);
            #1;
            check("mode_step", int'(mode), mseq[i]);
            check("sec_hold_step", int'(sec_hold),
                  (mseq[i] == 1 || mseq[i] == 2) ? 1 : 0);
            @(negedge clk);
            key_mode = 1'b0;
            cyc(2);
        end

        // single press in SET_MIN
        press_mode();
        press_mode();
        snap();
        key_up = 1'b1;
        repeat (3) tick10();
        key_up = 1'b0;
        cyc(3);
        check("single_min", cnt[1] - base[1], 1);
        check("single_others", cnt[0] + cnt[2] + cnt[3] - base[0] - base[2] - base[3], 0);

        // auto-repeat in SET_HR
        repeat (4) press_mode();
        check("in_set_hr", int'(mode), 1);
        snap();
        key_up = 1'b1;
        cyc(1);
        for (int i = 0; i < 25; i++) begin
            tick10();
            check("hold_blink", int'(blink), 0);
        end
        key_up = 1'b0;
        cyc(3);
        check("repeat_hr", cnt[0] - base[0], 16);
        check("repeat_others", cnt[1] + cnt[2] + cnt[3] - base[1] - base[2] - base[3], 0);

        // simultaneous edges in SET_AHR
        press_mode();
        press_mode();
        snap();
        key_mode = 1'b1;
        key_up   = 1'b1;
        @(posedge clk);
        #1;
        check("simul_mode", int'(mode), 4);
        @(negedge clk);
        cyc(4);
        key_mode = 1'b0;
        key_up   = 1'b0;
        cyc(3);
        check("simul_no_strobe",
              cnt[0] + cnt[1] + cnt[2] + cnt[3] - base[0] - base[1] - base[2] - base[3], 0);
        press_mode();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) key_mode = ~key_mode;
            if ($urandom_range(0, 7) == 0) key_up = ~key_up;
            tick_10hz = ($urandom_range(0, 3) == 0);
            tick_1hz  = ($urandom_range(0, 9) == 0);
            cyc(1);
        end
        key_mode  = 1'b0;
        key_up    = 1'b0;
        tick_10hz = 1'b0;
        tick_1hz  = 1'b0;
        cyc(3);

        // reset landing on a strobe in flight
        if (m_st == 0) press_mode();
        key_up = 1'b1;
        @(posedge clk);
        #2;
        check("inflight_strobe", int'(inc_hr | inc_min | inc_ahr | inc_amin), 1);
        CR = 1'b1;
        #1;
        check("abort_inc", int'({inc_hr, inc_min, inc_ahr, inc_amin}), 0);
        check("abort_mode", int'(mode), 0);
        check("abort_blink", int'(blink), 0);
        @(negedge clk);
        cyc(2);
        CR = 1'b0;
        snap();
        cyc(5);
        check("post_abort_no_edge",
              cnt[0] + cnt[1] + cnt[2] + cnt[3] - base[0] - base[1] - base[2] - base[3], 0);
        key_up = 1'b0;
        cyc(2);

        // idle behaviour in a set state
        press_mode();
        check("idle_enter", int'(mode), 1);
`ifdef SET_TIMEOUT_EN
        repeat (28) tick1();
        key_up = 1'b1;
        cyc(2);
        key_up = 1'b0;
        cyc(2);
        repeat (29) tick1();
        check("timeout_restart", int'(mode), 1);
        tick1();
        cyc(3);
        check("timeout_fire", int'(mode), 0);
`else
        repeat (100) tick1();
        check("no_timeout", int'(mode), 1);
`endif
        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
